// File: rtl/sys_array_fetcher_tiled.sv
// Tiled output-stationary systolic matrix multiplier.
// C = A * W is computed one ARRAY_W x ARRAY_L output tile at a time.
// Each tile is cleared, fed with skewed A rows and W columns, and then
// copied into the registered result matrix.
module sys_array_fetcher_tiled #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 5,
  parameter int ARRAY_L    = 5,
  parameter int MAX_M      = 16,
  parameter int MAX_K      = 16,
  parameter int MAX_N      = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                load_params,
  input  logic [$clog2(MAX_M+1)-1:0]          dim_m,
  input  logic [$clog2(MAX_K+1)-1:0]          dim_k,
  input  logic [$clog2(MAX_N+1)-1:0]          dim_n,
  input  logic                                start_comp,
  input  logic signed [DATA_WIDTH-1:0]        input_data_a [0:MAX_M-1][0:MAX_K-1],
  input  logic signed [DATA_WIDTH-1:0]        weights      [0:MAX_K-1][0:MAX_N-1],
  output logic signed [ACC_WIDTH-1:0]         out_data     [0:MAX_M-1][0:MAX_N-1],
  output logic                                ready,
  output logic                                done,
  output logic                                param_err
);

  localparam int DM_W = $clog2(MAX_M+1);
  localparam int DK_W = $clog2(MAX_K+1);
  localparam int DN_W = $clog2(MAX_N+1);
  localparam int MI_W = (MAX_M > 1) ? $clog2(MAX_M) : 1;
  localparam int KI_W = (MAX_K > 1) ? $clog2(MAX_K) : 1;
  localparam int NI_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int RB_W = $clog2(MAX_M+ARRAY_W+1);
  localparam int CB_W = $clog2(MAX_N+ARRAY_L+1);
  localparam int FC_W = $clog2(MAX_K+ARRAY_W+ARRAY_L+1);
  localparam int PW   = 2*DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, STORE, DONE} state_t;

  state_t            state_reg, state_next;
  logic [DM_W-1:0]   dim_m_reg;
  logic [DK_W-1:0]   dim_k_reg;
  logic [DN_W-1:0]   dim_n_reg;
  logic              param_err_reg;
  logic [FC_W-1:0]   feed_cnt_reg;
  logic [RB_W-1:0]   row_base_reg;
  logic [CB_W-1:0]   col_base_reg;

  logic              start_accept;
  logic              last_row_tile;
  logic              last_col_tile;
  logic              feed_last;

  logic signed [DATA_WIDTH-1:0] row_feed [0:ARRAY_W-1];
  logic signed [DATA_WIDTH-1:0] col_feed [0:ARRAY_L-1];
  logic signed [DATA_WIDTH-1:0] pe_a     [0:ARRAY_W-1][0:ARRAY_L-1];
  logic signed [DATA_WIDTH-1:0] pe_w     [0:ARRAY_W-1][0:ARRAY_L-1];
  logic signed [ACC_WIDTH-1:0]  pe_acc   [0:ARRAY_W-1][0:ARRAY_L-1];

  genvar gi, gj;

  // A start is only taken in IDLE with legal, non-zero latched dimensions.
  assign start_accept = (state_reg == IDLE) && start_comp && !param_err_reg &&
                        (|dim_m_reg) && (|dim_k_reg) && (|dim_n_reg);
  assign last_row_tile = (int'(row_base_reg) + ARRAY_W) >= int'(dim_m_reg);
  assign last_col_tile = (int'(col_base_reg) + ARRAY_L) >= int'(dim_n_reg);
  assign feed_last     = int'(feed_cnt_reg) == (int'(dim_k_reg) + ARRAY_W + ARRAY_L - 2);

  assign ready     = (state_reg == IDLE) || (state_reg == DONE);
  assign done      = (state_reg == DONE);
  assign param_err = param_err_reg;

  // Control registers: state, latched dimensions, feed counter, tile origin.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      dim_m_reg     <= '0;
      dim_k_reg     <= '0;
      dim_n_reg     <= '0;
      param_err_reg <= 1'b0;
      feed_cnt_reg  <= '0;
      row_base_reg  <= '0;
      col_base_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (load_params) begin
            dim_m_reg     <= dim_m;
            dim_k_reg     <= dim_k;
            dim_n_reg     <= dim_n;
            param_err_reg <= (dim_m == '0) || (dim_m > DM_W'(MAX_M)) ||
                             (dim_k == '0) || (dim_k > DK_W'(MAX_K)) ||
                             (dim_n == '0) || (dim_n > DN_W'(MAX_N));
          end
          if (start_accept) begin
            row_base_reg <= '0;
            col_base_reg <= '0;
          end
        end
        CLEAR: feed_cnt_reg <= '0;
        FEED:  feed_cnt_reg <= feed_cnt_reg + FC_W'(1);
        STORE: begin
          // Row-major tile walk: sweep columns, then step down one tile row.
          if (!last_col_tile) begin
            col_base_reg <= col_base_reg + CB_W'(ARRAY_L);
          end else if (!last_row_tile) begin
            col_base_reg <= '0;
            row_base_reg <= row_base_reg + RB_W'(ARRAY_W);
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_accept) state_next = CLEAR;
      CLEAR:   state_next = FEED;
      FEED:    if (feed_last) state_next = STORE;
      STORE:   state_next = (last_row_tile && last_col_tile) ? DONE : CLEAR;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Skewed A feed: row i gets A[row_base+i][t-i], zero when out of range.
  generate
    for (gi = 0; gi < ARRAY_W; gi++) begin : g_row_feed
      logic signed [DATA_WIDTH-1:0] feed_val;
      // Select the A element for this row at the current feed cycle.
      always_comb begin
        int r;
        int k;
        r = int'(row_base_reg) + gi;
        k = int'(feed_cnt_reg) - gi;
        feed_val = '0;
        if ((state_reg == FEED) && (k >= 0) && (k < int'(dim_k_reg)) && (r < int'(dim_m_reg)))
          feed_val = input_data_a[MI_W'(r)][KI_W'(k)];
      end
      assign row_feed[gi] = feed_val;
    end
  endgenerate

  // Skewed W feed: column j gets W[t-j][col_base+j], zero when out of range.
  generate
    for (gi = 0; gi < ARRAY_L; gi++) begin : g_col_feed
      logic signed [DATA_WIDTH-1:0] feed_val;
      // Select the W element for this column at the current feed cycle.
      always_comb begin
        int c;
        int k;
        c = int'(col_base_reg) + gi;
        k = int'(feed_cnt_reg) - gi;
        feed_val = '0;
        if ((state_reg == FEED) && (k >= 0) && (k < int'(dim_k_reg)) && (c < int'(dim_n_reg)))
          feed_val = weights[KI_W'(k)][NI_W'(c)];
      end
      assign col_feed[gi] = feed_val;
    end
  endgenerate

  // Processing elements: A moves right, W moves down, products accumulate in place.
  generate
    for (gi = 0; gi < ARRAY_W; gi++) begin : g_pe_row
      for (gj = 0; gj < ARRAY_L; gj++) begin : g_pe_col
        logic signed [DATA_WIDTH-1:0] a_in;
        logic signed [DATA_WIDTH-1:0] w_in;
        logic signed [DATA_WIDTH-1:0] a_reg;
        logic signed [DATA_WIDTH-1:0] w_reg;
        logic signed [PW-1:0]         prod;
        logic signed [ACC_WIDTH-1:0]  acc_reg;

        if (gj == 0) begin : g_a_edge
          assign a_in = row_feed[gi];
        end else begin : g_a_chain
          assign a_in = pe_a[gi][gj-1];
        end
        if (gi == 0) begin : g_w_edge
          assign w_in = col_feed[gj];
        end else begin : g_w_chain
          assign w_in = pe_w[gi-1][gj];
        end

        assign prod = PW'(a_in) * PW'(w_in);

        // Clear on CLEAR, shift and accumulate (wrapping) during FEED.
        always_ff @(posedge clk) begin
          if (!reset_n || (state_reg == CLEAR)) begin
            a_reg   <= '0;
            w_reg   <= '0;
            acc_reg <= '0;
          end else if (state_reg == FEED) begin
            a_reg   <= a_in;
            w_reg   <= w_in;
            acc_reg <= acc_reg + ACC_WIDTH'(prod);
          end
        end

        assign pe_a[gi][gj]   = a_reg;
        assign pe_w[gi][gj]   = w_reg;
        assign pe_acc[gi][gj] = acc_reg;
      end
    end
  endgenerate

  // Result matrix: each entry picks up its PE value when its tile is stored.
  generate
    for (gi = 0; gi < MAX_M; gi++) begin : g_out_row
      for (gj = 0; gj < MAX_N; gj++) begin : g_out_col
        logic                        store_hit;
        logic signed [ACC_WIDTH-1:0] store_val;
        logic signed [ACC_WIDTH-1:0] out_reg;

        // Locate the PE covering this entry in the current tile, if any.
        always_comb begin
          int di;
          int dj;
          di = gi - int'(row_base_reg);
          dj = gj - int'(col_base_reg);
          store_hit = 1'b0;
          store_val = '0;
          if ((state_reg == STORE) && (gi < int'(dim_m_reg)) && (gj < int'(dim_n_reg))) begin
            for (int i = 0; i < ARRAY_W; i++) begin
              for (int j = 0; j < ARRAY_L; j++) begin
                if ((i == di) && (j == dj)) begin
                  store_hit = 1'b1;
                  store_val = pe_acc[i][j];
                end
              end
            end
          end
        end

        // Zero on reset or accepted start, capture on store, otherwise hold.
        always_ff @(posedge clk) begin
          if (!reset_n || start_accept) begin
            out_reg <= '0;
          end else if (store_hit) begin
            out_reg <= store_val;
          end
        end

        assign out_data[gi][gj] = out_reg;
      end
    end
  endgenerate

endmodule

// File: tb/tb_sys_array_fetcher_tiled.sv
// Self-checking bench: two instances (5x5 array / 20-bit acc, 4x4 array / 16-bit acc)
// share stimulus and are compared against a plain matrix-product reference.
module tb_sys_array_fetcher_tiled;

  localparam int DW    = 8;
  localparam int MX    = 16;
  localparam int ACC_A = 20;
  localparam int ACC_B = 16;
  localparam int AW_A  = 5;
  localparam int AL_A  = 5;
  localparam int AW_B  = 4;
  localparam int AL_B  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       load_params;
  logic       start_comp;
  logic [4:0] dim_m, dim_k, dim_n;
  logic signed [DW-1:0]    a_mat [0:MX-1][0:MX-1];
  logic signed [DW-1:0]    w_mat [0:MX-1][0:MX-1];
  logic signed [ACC_A-1:0] out_a [0:MX-1][0:MX-1];
  logic signed [ACC_B-1:0] out_b [0:MX-1][0:MX-1];
  logic ready_a, done_a, perr_a;
  logic ready_b, done_b, perr_b;

  longint exp_c [0:MX-1][0:MX-1];
  int n_checks = 0;
  int n_fail   = 0;

  sys_array_fetcher_tiled u_dut_a (
    .clk(clk), .reset_n(reset_n), .load_params(load_params),
    .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n), .start_comp(start_comp),
    .input_data_a(a_mat), .weights(w_mat), .out_data(out_a),
    .ready(ready_a), .done(done_a), .param_err(perr_a)
  );

  sys_array_fetcher_tiled #(
    .ARRAY_W(AW_B), .ARRAY_L(AL_B), .ACC_WIDTH(ACC_B)
  ) u_dut_b (
    .clk(clk), .reset_n(reset_n), .load_params(load_params),
    .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n), .start_comp(start_comp),
    .input_data_a(a_mat), .weights(w_mat), .out_data(out_b),
    .ready(ready_b), .done(done_b), .param_err(perr_b)
  );

  task automatic check_value(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap_acc(input longint v, input int w);
    longint m;
    longint r;
    m = longint'(1) << w;
    r = v & (m - 1);
    if (r >= (m >> 1)) r = r - m;
    return r;
  endfunction

  function automatic int exp_latency(input int m, input int k, input int n,
                                     input int aw, input int al);
    int tiles;
    tiles = ((m + aw - 1) / aw) * ((n + al - 1) / al);
    return tiles * (k + aw + al + 1) + 1;
  endfunction

  // Reference: full-precision C = A*W over the active M x N region, zero elsewhere.
  task automatic build_model(input int m, input int k, input int n);
    for (int i = 0; i < MX; i++) begin
      for (int j = 0; j < MX; j++) begin
        exp_c[i][j] = 0;
        if (i < m && j < n)
          for (int kk = 0; kk < k; kk++)
            exp_c[i][j] += longint'(a_mat[i][kk]) * longint'(w_mat[kk][j]);
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < MX; i++)
      for (int j = 0; j < MX; j++)
        exp_c[i][j] = 0;
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < MX; i++) begin
      for (int j = 0; j < MX; j++) begin
        check_value($sformatf("%s_a[%0d][%0d]", tag, i, j), longint'(out_a[i][j]),
                    wrap_acc(exp_c[i][j], ACC_A));
        check_value($sformatf("%s_b[%0d][%0d]", tag, i, j), longint'(out_b[i][j]),
                    wrap_acc(exp_c[i][j], ACC_B));
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < MX; i++)
      for (int j = 0; j < MX; j++) begin
        a_mat[i][j] = DW'($urandom_range(0, 255));
        w_mat[i][j] = DW'($urandom_range(0, 255));
      end
  endtask

  task automatic load_dims(input int m, input int k, input int n);
    dim_m = 5'(m);
    dim_k = 5'(k);
    dim_n = 5'(n);
    load_params = 1'b1;
    @(negedge clk);
    load_params = 1'b0;
  endtask

  // Hold start high for a while; the design must stay ready and never finish.
  task automatic try_rejected(input string tag);
    int low_a = 0, low_b = 0, dn_a = 0, dn_b = 0;
    start_comp = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (!ready_a) low_a++;
      if (!ready_b) low_b++;
      if (done_a) dn_a++;
      if (done_b) dn_b++;
    end
    start_comp = 1'b0;
    check_value({tag, "_ready_low_a"}, low_a, 0);
    check_value({tag, "_ready_low_b"}, low_b, 0);
    check_value({tag, "_done_a"}, dn_a, 0);
    check_value({tag, "_done_b"}, dn_b, 0);
    $display("reject %s: ready_low=%0d/%0d done=%0d/%0d", tag, low_a, low_b, dn_a, dn_b);
  endtask

  // One computation; optionally pulses load_params/start_comp while busy.
  task automatic run_comp(input string tag, input int m, input int k, input int n,
                          input bit inject);
    int lat_a = -1, lat_b = -1, pul_a = 0, pul_b = 0;
    int el_a, el_b, budget;
    el_a = exp_latency(m, k, n, AW_A, AL_A);
    el_b = exp_latency(m, k, n, AW_B, AL_B);
    budget = ((el_a > el_b) ? el_a : el_b) + 6;
    start_comp = 1'b1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start_comp  = 1'b0;
      load_params = 1'b0;
      if (cyc == 1) begin
        check_value({tag, "_busy_a"}, longint'(ready_a), 0);
        check_value({tag, "_busy_b"}, longint'(ready_b), 0);
      end
      if (inject && cyc == 4) begin
        dim_m = 5'd1; dim_k = 5'd1; dim_n = 5'd1;
        load_params = 1'b1;
        start_comp  = 1'b1;
      end
      if (inject && cyc == 5) begin
        dim_m = 5'(m); dim_k = 5'(k); dim_n = 5'(n);
      end
      if (done_a) begin
        pul_a++;
        if (lat_a < 0) begin
          lat_a = cyc;
          check_value({tag, "_ready_done_a"}, longint'(ready_a), 1);
        end
      end
      if (done_b) begin
        pul_b++;
        if (lat_b < 0) begin
          lat_b = cyc;
          check_value({tag, "_ready_done_b"}, longint'(ready_b), 1);
        end
      end
    end
    check_value({tag, "_latency_a"}, lat_a, el_a);
    check_value({tag, "_latency_b"}, lat_b, el_b);
    check_value({tag, "_pulses_a"}, pul_a, 1);
    check_value({tag, "_pulses_b"}, pul_b, 1);
    $display("run %s: m=%0d k=%0d n=%0d latency=%0d/%0d (expect %0d/%0d) pulses=%0d/%0d",
             tag, m, k, n, lat_a, lat_b, el_a, el_b, pul_a, pul_b);
  endtask

  initial begin
    int m, k, n;
    int dn_a, dn_b;
    reset_n     = 1'b0;
    load_params = 1'b0;
    start_comp  = 1'b0;
    dim_m = '0; dim_k = '0; dim_n = '0;
    for (int i = 0; i < MX; i++)
      for (int j = 0; j < MX; j++) begin
        a_mat[i][j] = '0;
        w_mat[i][j] = '0;
      end

    // Reset state.
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_value("rst_ready_a", longint'(ready_a), 1);
    check_value("rst_ready_b", longint'(ready_b), 1);
    check_value("rst_done_a", longint'(done_a), 0);
    check_value("rst_done_b", longint'(done_b), 0);
    check_value("rst_perr_a", longint'(perr_a), 0);
    check_value("rst_perr_b", longint'(perr_b), 0);
    clear_model();
    check_outputs("rst");
    $display("reset: ready=%0d/%0d perr=%0d/%0d", ready_a, ready_b, perr_a, perr_b);

    // Dims are zero after reset, so start must be refused.
    try_rejected("dims_zero");

    // Small deterministic matrices, M=4 K=3 N=4.
    for (int i = 0; i < MX; i++)
      for (int j = 0; j < MX; j++) begin
        a_mat[i][j] = DW'(((i + 2*j) % 5) - 2);
        w_mat[i][j] = DW'(((3*i + j) % 7) - 3);
      end
    load_dims(4, 3, 4);
    build_model(4, 3, 4);
    run_comp("small", 4, 3, 4, 1'b0);
    check_value("small_c00_golden", longint'(out_a[0][0]), 12);
    check_outputs("small");

    // Partial tiles plus busy-time load/start pulses, M=6 K=5 N=7.
    fill_random();
    load_dims(6, 5, 7);
    build_model(6, 5, 7);
    run_comp("partial", 6, 5, 7, 1'b1);
    check_outputs("partial");

    // Accumulator wrap: all 127, K=16.
    for (int i = 0; i < MX; i++)
      for (int j = 0; j < MX; j++) begin
        a_mat[i][j] = 8'sd127;
        w_mat[i][j] = 8'sd127;
      end
    load_dims(3, 16, 3);
    build_model(3, 16, 3);
    run_comp("wrap", 3, 16, 3, 1'b0);
    check_value("wrap_acc20", longint'(out_a[2][2]), 258064);
    check_value("wrap_acc16", longint'(out_b[2][2]), -4080);
    check_outputs("wrap");

    // Illegal dimensions.
    load_dims(4, 0, 4);
    check_value("perr_k0_a", longint'(perr_a), 1);
    check_value("perr_k0_b", longint'(perr_b), 1);
    try_rejected("k_zero");
    load_dims(4, 4, 17);
    check_value("perr_n17_a", longint'(perr_a), 1);
    check_value("perr_n17_b", longint'(perr_b), 1);
    try_rejected("n_over");
    load_dims(2, 2, 2);
    check_value("perr_clear_a", longint'(perr_a), 0);
    check_value("perr_clear_b", longint'(perr_b), 0);

    // Randomized sizes and data.
    for (int t = 0; t < 4; t++) begin
      m = $urandom_range(1, MX);
      k = $urandom_range(1, MX);
      n = $urandom_range(1, MX);
      fill_random();
      load_dims(m, k, n);
      build_model(m, k, n);
      run_comp($sformatf("rand%0d", t), m, k, n, 1'b0);
      check_outputs($sformatf("rand%0d", t));
    end

    // Reset during the second tile's feed phase aborts the job.
    fill_random();
    load_dims(6, 5, 7);
    dn_a = 0;
    dn_b = 0;
    start_comp = 1'b1;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      start_comp = 1'b0;
      if (cyc == 20) reset_n = 1'b0;
      if (cyc == 21) begin
        reset_n = 1'b1;
        check_value("abort_ready_a", longint'(ready_a), 1);
        check_value("abort_ready_b", longint'(ready_b), 1);
        check_value("abort_perr_a", longint'(perr_a), 0);
      end
      if (done_a) dn_a++;
      if (done_b) dn_b++;
    end
    check_value("abort_done_a", dn_a, 0);
    check_value("abort_done_b", dn_b, 0);
    clear_model();
    check_outputs("abort");
    $display("abort: done=%0d/%0d ready=%0d/%0d", dn_a, dn_b, ready_a, ready_b);

    // Fresh job after the abort.
    load_dims(6, 5, 7);
    build_model(6, 5, 7);
    run_comp("after_abort", 6, 5, 7, 1'b0);
    check_outputs("after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sys_array_fetcher_tiled.md
SYS_ARRAY_FETCHER_TILED -- requirements
Module: sys_array_fetcher_tiled

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, signed element width of A and W.
REQ-002 SHALL have parameter ARRAY_W, default 5, PE rows in internal systolic array.
REQ-003 SHALL have parameter ARRAY_L, default 5, PE columns in internal systolic array.
REQ-004 SHALL have parameters MAX_M, MAX_K, MAX_N, default 16 each, maximum runtime matrix dimensions.
REQ-005 SHALL have parameter ACC_WIDTH, default 2*DATA_WIDTH+4, signed accumulator and result width.
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-008 SHALL have port load_params  input  1  one-cycle strobe latching dim_m/dim_k/dim_n.
REQ-009 SHALL have ports dim_m, dim_k, dim_n  input  $clog2(MAX_x+1) each  runtime sizes: A is M x K, W is K x N.
REQ-010 SHALL have port start_comp  input  1  start request, level sampled.
REQ-011 SHALL have port input_data_a  input  signed [DATA_WIDTH-1:0] [0:MAX_M-1][0:MAX_K-1]  matrix A.
REQ-012 SHALL have port weights  input  signed [DATA_WIDTH-1:0] [0:MAX_K-1][0:MAX_N-1]  matrix W.
REQ-013 SHALL have port out_data  output  signed [ACC_WIDTH-1:0] [0:MAX_M-1][0:MAX_N-1]  registered result C = A*W.
REQ-014 SHALL have port ready  output  1  high when idle and accepting start.
REQ-015 SHALL have port done  output  1  one-cycle pulse on completion.
REQ-016 SHALL have port param_err  output  1  sticky flag: latched dims illegal.

Function
REQ-017 SHALL implement FSM states IDLE, CLEAR, FEED, STORE, DONE.
REQ-018 SHALL, in IDLE, latch dims on load_params; param_err set if any dim is 0 or exceeds its MAX, else cleared.
REQ-019 SHALL, in IDLE with start_comp=1 and param_err=0, zero all out_data, set tile indices (0,0), go to CLEAR; ready low from next cycle.
REQ-020 SHALL ignore start_comp while param_err=1 (stay IDLE, ready high, no done).
REQ-021 SHALL ignore load_params and start_comp in every state except IDLE.
REQ-022 SHALL tile C into ceil(M/ARRAY_W) x ceil(N/ARRAY_L) tiles, processed row-major.
REQ-023 SHALL, in CLEAR (1 cycle), zero all PE accumulators and A/W pipeline registers.
REQ-024 SHALL, in FEED, run K+ARRAY_W+ARRAY_L-1 cycles; at feed cycle t row i receives A[tr*ARRAY_W+i][t-i], column j receives W[t-j][tc*ARRAY_L+j].
REQ-025 SHALL substitute 0 for any fed index out of range (t-i<0, t-i>=K, row>=M, col>=N).
REQ-026 SHALL have each PE register A right and W down one per cycle; PE(i,j) sees k-th product at feed cycle k+i+j.
REQ-027 SHALL accumulate products in ACC_WIDTH two's-complement, wrapping on overflow (no saturation).
REQ-028 SHALL, in STORE (1 cycle), write PE(i,j) to out_data[tr*ARRAY_W+i][tc*ARRAY_L+j] only if row<M and col<N.
REQ-029 SHALL, after STORE, advance to next tile and CLEAR, or to DONE after last tile.
REQ-030 SHALL, in DONE (1 cycle), assert done=1, ready=1, then return to IDLE.
REQ-031 SHALL leave out_data entries outside M x N at 0, and hold out_data stable from DONE until next accepted start.
REQ-032 SHALL have latency: done high exactly tiles*(K+ARRAY_W+ARRAY_L+1)+1 cycles after the edge accepting start_comp.
REQ-033 SHALL not require A/W stable except during FEED; sampling occurs only in FEED.

Reset
REQ-034 SHALL, on clk edge with reset_n=0, in any state: FSM to IDLE, ready=1, done=0, param_err=0, dims to 0, all out_data and accumulators to 0.
REQ-035 SHALL treat reset mid-computation as abort: no done pulse, partial results discarded.
REQ-036 SHALL, with dims 0 after reset, reject start until a legal load_params (param_err=0 but start ignored while any dim=0).

Verification
REQ-037 Defaults, load M=4,K=3,N=4, A=B=small ints from hex, start -> done at cycle 15 after start edge, out_data[0..3][0..3] equals golden c_data, rest 0.
REQ-038 ARRAY_W=ARRAY_L=4, M=6,K=5,N=7 -> 4 tiles, done at cycle 57, partial-tile edges correct, rows 6+ / cols 7+ zero.
REQ-039 load K=0 or N=MAX_N+1 -> param_err=1, start ignored, ready stays 1, no done; legal reload clears param_err.
REQ-040 A all 127, W all 127, K=16, ACC_WIDTH=20 -> each C = 258064 mod 2^20 as signed = 258064; with ACC_WIDTH=16 result wraps to -4080.
REQ-041 reset_n=0 during FEED of tile 2 -> next cycle ready=1, out_data all 0, no done; fresh start completes correctly.
REQ-042 start_comp and load_params pulsed while busy -> ignored; dims and latency unchanged, single done pulse.
